// File: rtl/spi_slave_alu.sv
// SPI-clocked ALU slave: receives start bit, A, B and a 2-bit opcode on MOSI (LSB first),
// latches the RES_W-bit result onto leds/carry and shifts it back on MISO.
module spi_slave_alu #(
  parameter int OP_W = 4
) (
  input  logic            clk_arduino,
  input  logic            reset,
  input  logic            MOSI,
  input  logic            CS,
  output logic            MISO,
  output logic [OP_W-1:0] leds,
  output logic            carry,
  output logic            frame_done,
  output logic [2:0]      dbg_state
);

  localparam int RES_W = OP_W + 1;
  localparam int CNT_W = $clog2(OP_W + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RX_A  = 3'd1,
    RX_B  = 3'd2,
    RX_OP = 3'd3,
    EXEC  = 3'd4,
    TX    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]   b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic [RES_W-2:0]  tx_q, tx_d;
  logic              miso_q, miso_d;
  logic [OP_W-1:0]   leds_q, leds_d;
  logic              carry_q, carry_d;
  logic              done_q, done_d;
  logic [RES_W-1:0]  a_ext, b_ext, alu_res;

  assign a_ext = {1'b0, a_q};
  assign b_ext = {1'b0, b_q};

  // Subtraction in RES_W bits leaves the borrow in the top bit.
  always_comb begin
    alu_res = '0;
    case (op_q)
      2'b00:   alu_res = a_ext + b_ext;
      2'b01:   alu_res = a_ext - b_ext;
      2'b10:   alu_res = a_ext & b_ext;
      default: alu_res = a_ext | b_ext;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tx_d    = tx_q;
    miso_d  = miso_q;
    leds_d  = leds_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!CS && MOSI) begin
          state_d = RX_A;
          cnt_d   = '0;
        end
      end
      RX_A: begin
        a_d   = {MOSI, a_q[OP_W-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(OP_W - 1)) begin
          state_d = RX_B;
          cnt_d   = '0;
        end
      end
      RX_B: begin
        b_d   = {MOSI, b_q[OP_W-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(OP_W - 1)) begin
          state_d = RX_OP;
          cnt_d   = '0;
        end
      end
      RX_OP: begin
        op_d  = {MOSI, op_q[1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = EXEC;
          cnt_d   = '0;
        end
      end
      EXEC: begin
        leds_d  = alu_res[OP_W-1:0];
        carry_d = alu_res[OP_W];
        done_d  = 1'b1;
        miso_d  = alu_res[0];
        tx_d    = alu_res[RES_W-1:1];
        state_d = TX;
        cnt_d   = '0;
      end
      TX: begin
        // Bit 0 went out at EXEC; the last edge here only retires the final bit.
        if (cnt_q == CNT_W'(RES_W - 1)) begin
          miso_d  = 1'b0;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          miso_d = tx_q[0];
          tx_d   = tx_q >> 1;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (CS && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      tx_d    = '0;
      miso_d  = 1'b0;
      leds_d  = leds_q;
      carry_d = carry_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_arduino or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tx_q    <= '0;
      miso_q  <= 1'b0;
      leds_q  <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tx_q    <= tx_d;
      miso_q  <= miso_d;
      leds_q  <= leds_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign MISO       = miso_q;
  assign leds       = leds_q;
  assign carry      = carry_q;
  assign frame_done = done_q;
  assign dbg_state  = state_q;

endmodule
